// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for the ID stage of an in-order pipeline.
// Tracks, per architectural register, how many pipeline advances remain
// before the youngest in-flight producer's result can be forwarded. It also
// tracks whether a serialising (CSR/ertn/idle-class) instruction is
// outstanding. From that state and the current ID instruction it decides
// combinationally whether ID must stall.
module hazard_scoreboard #(
  parameter int NUM_SRC = 3,
  parameter int NUM_GR  = 32,
  parameter int GR_W    = 5,
  parameter int LAT_W   = 2
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    issue_valid,
  input  logic [NUM_SRC*GR_W-1:0] issue_rs,
  input  logic [NUM_SRC-1:0]      issue_rs_en,
  input  logic [GR_W-1:0]         issue_rd,
  input  logic                    issue_wen,
  input  logic [LAT_W-1:0]        issue_lat,
  input  logic                    issue_serial,
  input  logic                    ex_allow_in,
  input  logic                    pipe_adv,
  input  logic                    serial_done,
  input  logic                    flush,
  output logic                    stall,
  output logic                    issue_fire,
  output logic [NUM_GR-1:0]       busy_vec,
  output logic                    serial_pending
);

  // Per-register countdown of pipeline advances until forwardable.
  logic [LAT_W-1:0] cnt_q [NUM_GR];
  logic [LAT_W-1:0] cnt_d [NUM_GR];

  // Serialising instruction in flight.
  logic serial_q;
  logic serial_d;

  // Decoded source register numbers and per-port hazard flags.
  logic [GR_W-1:0]    src_num [NUM_SRC];
  logic [NUM_SRC-1:0] src_hazard;

  logic any_busy;
  logic load_en;
  logic serial_set;

  // A register is busy while its countdown is nonzero.
  always_comb begin
    for (int r = 0; r < NUM_GR; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  assign any_busy       = |busy_vec;
  assign serial_pending = serial_q;

  // Evaluate every source port in parallel against pre-issue state only, so
  // an instruction that reads and writes the same register never hazards on
  // itself.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    src_hazard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_num[i]    = issue_rs[i*GR_W +: GR_W];
      src_hazard[i] = issue_rs_en[i] && (src_num[i] != '0) && busy_vec[src_num[i]];
    end
  end

  // Stall and fire are purely combinational, so ID is released in the same
  // cycle in which the last blocking counter reads zero.
  assign stall = issue_valid &&
                 ((|src_hazard) || serial_q || (issue_serial && any_busy));

  assign issue_fire = issue_valid && ex_allow_in && !stall;

  assign load_en    = issue_fire && issue_wen && (issue_rd != '0);
  assign serial_set = issue_fire && issue_serial;

  // Counter next state. Flush beats everything. A fresh load beats a
  // decrement because the youngest producer defines when the register
  // becomes forwardable. Decrements saturate at zero.
  always_comb begin
    for (int r = 0; r < NUM_GR; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (load_en && (issue_rd == GR_W'(r))) begin
        cnt_d[r] = issue_lat;
      end else if (pipe_adv && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
    end
    // Register 0 is hardwired zero and never becomes busy.
    cnt_d[0] = '0;
  end

  // Serial-pending next state. A coincident set and clear resolves to a
  // clear only when a serial instruction was already outstanding, so the
  // clear acts on the older instruction and the new one stays tracked.
  always_comb begin
    serial_d = serial_q;
    if (flush) begin
      serial_d = 1'b0;
    end else if (serial_set && serial_done) begin
      serial_d = !serial_q;
    end else if (serial_set) begin
      serial_d = 1'b1;
    end else if (serial_done) begin
      serial_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously by resetn.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the counter array must be reset like ordinary flops. Stale
      // busy bits after reset would deadlock issue, so this array is not a
      // RAM whose contents may power up unknown.
      for (int r = 0; r < NUM_GR; r++) begin
        cnt_q[r] <= '0;
      end
      serial_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      for (int r = 0; r < NUM_GR; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      serial_q <= serial_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. A behavioural model of the
// per-register countdowns and the serial flag is compared against the DUT
// on every falling clock edge. Directed sequences exercise the named corner
// cases, and a randomised phase follows.
module tb_hazard_scoreboard;

  localparam int NUM_SRC = 3;
  localparam int NUM_GR  = 32;
  localparam int GR_W    = 5;
  localparam int LAT_W   = 2;

  logic                    aclk;
  logic                    resetn;
  logic                    issue_valid;
  logic [NUM_SRC*GR_W-1:0] issue_rs;
  logic [NUM_SRC-1:0]      issue_rs_en;
  logic [GR_W-1:0]         issue_rd;
  logic                    issue_wen;
  logic [LAT_W-1:0]        issue_lat;
  logic                    issue_serial;
  logic                    ex_allow_in;
  logic                    pipe_adv;
  logic                    serial_done;
  logic                    flush;
  logic                    stall;
  logic                    issue_fire;
  logic [NUM_GR-1:0]       busy_vec;
  logic                    serial_pending;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: remaining advances per register, plus the serial flag.
  int m_cnt [NUM_GR];
  bit m_ser;

  hazard_scoreboard #(
    .NUM_SRC(NUM_SRC), .NUM_GR(NUM_GR), .GR_W(GR_W), .LAT_W(LAT_W)
  ) dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rs_en   (issue_rs_en),
    .issue_rd      (issue_rd),
    .issue_wen     (issue_wen),
    .issue_lat     (issue_lat),
    .issue_serial  (issue_serial),
    .ex_allow_in   (ex_allow_in),
    .pipe_adv      (pipe_adv),
    .serial_done   (serial_done),
    .flush         (flush),
    .stall         (stall),
    .issue_fire    (issue_fire),
    .busy_vec      (busy_vec),
    .serial_pending(serial_pending)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_SRC*GR_W-1:0] pack3(input logic [GR_W-1:0] a,
                                                   input logic [GR_W-1:0] b,
                                                   input logic [GR_W-1:0] c);
    return {c, b, a};
  endfunction

  task automatic idle();
    issue_valid  = 1'b0;
    issue_rs     = '0;
    issue_rs_en  = '0;
    issue_rd     = '0;
    issue_wen    = 1'b0;
    issue_lat    = '0;
    issue_serial = 1'b0;
    ex_allow_in  = 1'b1;
    pipe_adv     = 1'b0;
    serial_done  = 1'b0;
    flush        = 1'b0;
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Compare process: derive expected outputs from the model state and the
  // current inputs, then advance the model by one clock.
  always @(negedge aclk) begin
    bit               hz;
    bit               e_stall;
    bit               e_fire;
    bit               any_b;
    bit               set_s;
    logic [NUM_GR-1:0] e_busy;
    int               rs;

    if (!resetn) begin
      for (int r = 0; r < NUM_GR; r++) m_cnt[r] = 0;
      m_ser = 1'b0;
    end

    e_busy = '0;
    for (int r = 0; r < NUM_GR; r++) e_busy[r] = (m_cnt[r] > 0);
    any_b = (e_busy != '0);

    hz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = int'(issue_rs[i*GR_W +: GR_W]);
      if (issue_rs_en[i] && rs != 0 && m_cnt[rs] > 0) hz = 1'b1;
    end

    e_stall = issue_valid && (hz || m_ser || (issue_serial && any_b));
    e_fire  = issue_valid && ex_allow_in && !e_stall;

    check("cyc_stall", stall, e_stall);
    check("cyc_fire", issue_fire, e_fire);
    check("cyc_busy_vec", busy_vec, e_busy);
    check("cyc_serial_pending", serial_pending, m_ser);

    if (resetn) begin
      if (flush) begin
        for (int r = 0; r < NUM_GR; r++) m_cnt[r] = 0;
        m_ser = 1'b0;
      end else begin
        for (int r = 1; r < NUM_GR; r++) begin
          if (e_fire && issue_wen && int'(issue_rd) == r) m_cnt[r] = int'(issue_lat);
          else if (pipe_adv && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
        end
        set_s = e_fire && issue_serial;
        m_ser = serial_done ? (set_s && !m_ser) : (m_ser || set_s);
      end
    end
  end

  initial begin
    int n;

    for (int r = 0; r < NUM_GR; r++) m_cnt[r] = 0;
    m_ser  = 1'b0;
    resetn = 1'b0;
    idle();

    // In reset: cleared state, so a reader of r5 fires without stalling.
    issue_valid = 1'b1; issue_rs = pack3(5, 0, 0); issue_rs_en = 3'b001;
    @(negedge aclk); @(negedge aclk); #1;
    check("rst_stall", stall, 0);
    check("rst_fire", issue_fire, 1);
    check("rst_busy", busy_vec, 0);
    check("rst_serial", serial_pending, 0);
    step();
    resetn = 1'b1;
    idle();

    // Load r5 lat=2, then a dependent add stalls exactly two cycles.
    step(); idle();
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5; issue_lat = 2; pipe_adv = 1'b1;
    #2 check("load_fire", issue_fire, 1);
    step(); idle();
    issue_valid = 1'b1; issue_rs = pack3(5, 7, 0); issue_rs_en = 3'b011;
    issue_rd = 6; issue_wen = 1'b1; pipe_adv = 1'b1;
    #2 check("model_cnt5", m_cnt[5], 2);
    n = 0;
    while (stall && n < 8) begin
      n++;
      step();
      #2;
    end
    check("load_use_stall_cycles", n, 2);
    check("load_use_fire", issue_fire, 1);

    // ALU write r3 lat=0, reader next cycle never stalls.
    step(); idle();
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 3; issue_lat = 0;
    #2 check("alu_fire", issue_fire, 1);
    step(); idle();
    issue_valid = 1'b1; issue_rs = pack3(3, 0, 0); issue_rs_en = 3'b001;
    #2 check("alu_reader_stall", stall, 0);
    check("alu_busy3", busy_vec[3], 0);

    // WAW: r8 at cnt=1 with pipe_adv, a new lat=3 writer loads 3.
    step(); idle();
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 8; issue_lat = 1;
    step(); idle();
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 8; issue_lat = 3; pipe_adv = 1'b1;
    #2 check("waw_model_pre", m_cnt[8], 1);
    check("waw_fire", issue_fire, 1);
    step(); idle(); pipe_adv = 1'b1;
    #2 check("waw_model_cnt8", m_cnt[8], 3);
    check("waw_busy8_a", busy_vec[8], 1);
    step();
    step();
    #2 check("waw_busy8_c", busy_vec[8], 1);
    step();
    #2 check("waw_busy8_d", busy_vec[8], 0);

    // CSR from idle sets serial_pending and blocks until serial_done.
    step(); idle();
    issue_valid = 1'b1; issue_serial = 1'b1;
    #2 check("csr_stall", stall, 0);
    check("csr_fire", issue_fire, 1);
    step(); idle();
    issue_valid = 1'b1; issue_rs = pack3(1, 2, 0); issue_rs_en = 3'b011;
    #2 check("csr_pending", serial_pending, 1);
    check("csr_block_a", stall, 1);
    step();
    #2 check("csr_block_b", issue_fire, 0);
    serial_done = 1'b1;
    step();
    serial_done = 1'b0;
    #2 check("csr_cleared", serial_pending, 0);
    check("csr_release_fire", issue_fire, 1);
    step(); idle();
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 9; issue_lat = 3;
    step(); idle();
    issue_valid = 1'b1; issue_serial = 1'b1;
    #2 check("csr_busy_stall", stall, 1);

    // Flush clears busy registers and serial_pending; blocked reader fires.
    step(); idle(); flush = 1'b1;
    step(); idle();
    issue_valid = 1'b1; issue_serial = 1'b1; issue_wen = 1'b1; issue_rd = 12; issue_lat = 3;
    #2 check("flush_csr_fire", issue_fire, 1);
    step(); idle();
    issue_valid = 1'b1; issue_rs = pack3(12, 0, 0); issue_rs_en = 3'b001; flush = 1'b1;
    #2 check("flush_pre_busy", busy_vec, 32'h0000_1000);
    check("flush_pre_serial", serial_pending, 1);
    check("flush_pre_stall", stall, 1);
    step(); flush = 1'b0;
    #2 check("flush_busy", busy_vec, 0);
    check("flush_serial", serial_pending, 0);
    check("flush_reader_fire", issue_fire, 1);

    // A fire during flush has no state effect.
    step(); idle();
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 13; issue_lat = 2; flush = 1'b1;
    #2 check("flush_discard_fire", issue_fire, 1);
    step(); idle();
    #2 check("flush_discard_busy", busy_vec, 0);
    check("flush_discard_model", m_cnt[13], 0);

    // Register 0: reader and writer never hazard.
    step(); idle();
    issue_valid = 1'b1; issue_rs = pack3(0, 0, 0); issue_rs_en = 3'b111;
    issue_rd = 0; issue_wen = 1'b1; issue_lat = 3;
    #2 check("r0_fire", issue_fire, 1);
    step();
    #2 check("r0_stall", stall, 0);
    check("r0_busy0", busy_vec[0], 0);

    // Self-reference uses pre-issue state; the repeat then hazards.
    step(); idle();
    issue_valid = 1'b1; issue_rs = pack3(14, 0, 0); issue_rs_en = 3'b001;
    issue_rd = 14; issue_wen = 1'b1; issue_lat = 2;
    #2 check("self_fire", issue_fire, 1);
    step();
    #2 check("self_repeat_stall", stall, 1);

    // Asynchronous reset mid-cycle clears state with no clock edge.
    step(); idle();
    #2 check("arst_pre_busy14", busy_vec[14], 1);
    resetn = 1'b0;
    #1 check("arst_busy", busy_vec, 0);
    check("arst_serial", serial_pending, 0);
    step();
    resetn = 1'b1;

    // Randomised phase with a small register window to provoke hazards.
    for (int c = 0; c < 2000; c++) begin
      step();
      issue_valid = ($urandom_range(0, 99) < 80);
      for (int i = 0; i < NUM_SRC; i++) begin
        issue_rs[i*GR_W +: GR_W] = GR_W'(($urandom_range(0, 3) == 0) ?
                                          $urandom_range(0, 31) : $urandom_range(0, 7));
      end
      issue_rs_en  = NUM_SRC'($urandom);
      issue_rd     = GR_W'(($urandom_range(0, 3) == 0) ?
                           $urandom_range(0, 31) : $urandom_range(0, 7));
      issue_wen    = ($urandom_range(0, 99) < 70);
      issue_lat    = LAT_W'($urandom);
      issue_serial = ($urandom_range(0, 99) < 8);
      ex_allow_in  = ($urandom_range(0, 99) < 85);
      pipe_adv     = ($urandom_range(0, 99) < 70);
      serial_done  = ($urandom_range(0, 99) < 12);
      flush        = ($urandom_range(0, 99) < 3);
    end

    step(); idle();
    @(negedge aclk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 3: source-register read ports per issuing instruction (rj, rk, rd-as-source).
REQ-002 Parameter NUM_GR, default 32: architectural general registers; register 0 is hardwired zero.
REQ-003 Parameter GR_W, default 5: register-number width, equal to clog2(NUM_GR).
REQ-004 Parameter LAT_W, default 2: width of the producer-latency field and of each per-register countdown.
REQ-005 aclk  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 issue_valid  input  1  the ID stage holds a valid instruction.
REQ-008 issue_rs  input  NUM_SRC*GR_W  source register numbers; port i occupies bits [i*GR_W +: GR_W].
REQ-009 issue_rs_en  input  NUM_SRC  per-port flag: this source is actually read.
REQ-010 issue_rd  input  GR_W  destination register number.
REQ-011 issue_wen  input  1  the instruction writes issue_rd.
REQ-012 issue_lat  input  LAT_W  pipeline advances after issue before the result can be forwarded; 0 means forwardable to the next instruction (ALU op).
REQ-013 issue_serial  input  1  CSR/ertn/idle-class instruction that requires a drained pipeline and blocks later issue.
REQ-014 ex_allow_in  input  1  the EX stage can accept an instruction this cycle.
REQ-015 pipe_adv  input  1  the EX-to-MEM-to-WB pipeline advanced by one slot this cycle.
REQ-016 serial_done  input  1  the outstanding serial instruction has retired in WB.
REQ-017 flush  input  1  exception/ertn/idle flush from MEM or WB; kills all in-flight younger instructions.
REQ-018 stall  output  1  combinational; ID must hold its instruction this cycle.
REQ-019 issue_fire  output  1  combinational; issue_valid AND ex_allow_in AND NOT stall.
REQ-020 busy_vec  output  NUM_GR  registered; bit r=1 when register r has a pending unforwardable write.
REQ-021 serial_pending  output  1  registered; a serial instruction has issued and not yet retired.

Function
REQ-022 The block SHALL hold one LAT_W-bit countdown cnt[r] per register; busy_vec[r] = (cnt[r] != 0); cnt[0] SHALL remain 0.
REQ-023 Source hazard on port i = issue_rs_en[i] AND issue_rs[i] != 0 AND busy_vec[issue_rs[i]]; all ports SHALL be evaluated in parallel.
REQ-024 stall = issue_valid AND (any source hazard OR serial_pending OR (issue_serial AND any bit of busy_vec set)).
REQ-025 On issue_fire with issue_wen=1 and issue_rd != 0, cnt[issue_rd] SHALL load issue_lat at the next edge.
REQ-026 On each pipe_adv=1 cycle, every nonzero cnt SHALL decrement by 1; without pipe_adv, counters SHALL hold.
REQ-027 When a load (REQ-025) and a decrement (REQ-026) target the same register in one cycle, the load SHALL win (WAW: the youngest producer defines busy).
REQ-028 Counters SHALL saturate at 0 and never wrap.
REQ-029 On issue_fire with issue_serial=1, serial_pending SHALL set at the next edge; serial_done SHALL clear it; set and clear in the same cycle: clear wins only if serial_pending was already 1, otherwise set wins.
REQ-030 flush=1 SHALL clear all counters and serial_pending at the next edge, overriding REQ-025 to REQ-029; issue_fire is still computed but its state effect SHALL be discarded.
REQ-031 A source that matches the instruction's own issue_rd SHALL use pre-issue state only (no self-hazard).
REQ-032 The stall-to-issue path SHALL be purely combinational from registered state plus ID inputs; there is no latency from a counter reaching 0 to release of the stall.

Reset
REQ-033 While resetn=0: all cnt = 0, busy_vec = 0, serial_pending = 0; stall and issue_fire follow REQ-024/REQ-019 with cleared state.
REQ-034 Reset asserted mid-operation SHALL clear all state asynchronously, with no dependence on aclk.

Verification
REQ-035 Load r5 with lat=2, then add r6,r5,r7 every cycle with pipe_adv=1 -> stall=1 for exactly 2 cycles, then issue_fire=1.
REQ-036 ALU write r3 with lat=0, then a reader of r3 next cycle -> stall=0; busy_vec[3] stays 0.
REQ-037 r8 busy with cnt=1 and pipe_adv=1, while a new lat=3 writer of r8 fires the same cycle -> cnt[8]=3 next cycle (load wins).
REQ-038 CSR fire while busy_vec=0 -> serial_pending=1 and every following issue stalled until serial_done; a CSR arriving while busy_vec != 0 stalls.
REQ-039 Multiple busy registers plus serial_pending, then flush=1 -> busy_vec=0 and serial_pending=0 next cycle; a pending reader fires at once.
REQ-040 Reader of r0 with issue_rs_en=1, and a writer to r0 with lat=3 -> never stalls; busy_vec[0]=0 throughout.
